// File: rtl/mem_data_bridge_pkg.sv
// cpu_defs: shared definitions for the MEM-stage data bridge.
//   - br_state_e : bridge FSM encoding (BR_IDLE..BR_DONE)
//   - SZ_*       : data_size bus codes
//   - helpers    : access size from a byte mask, store-lane replication,
//                  alignment test (used only when DATA_BRIDGE_ALIGN_CHECK_EN
//                  is defined)
package cpu_defs;

  typedef enum logic [2:0] {
    BR_IDLE  = 3'd0,
    BR_REQ   = 3'd1,
    BR_WAIT  = 3'd2,
    BR_DRAIN = 3'd3,
    BR_DONE  = 3'd4
  } br_state_e;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  // Access size is the number of active byte lanes: 1, 2 or 4.
  function automatic logic [1:0] mask_size(input logic [3:0] mask);
    logic [2:0] cnt;
    cnt = {2'b00, mask[0]} + {2'b00, mask[1]} + {2'b00, mask[2]} + {2'b00, mask[3]};
    case (cnt)
      3'd1:    mask_size = SZ_BYTE;
      3'd2:    mask_size = SZ_HALF;
      default: mask_size = SZ_WORD;
    endcase
  endfunction

  // Replicate the low byte/half of the raw register value across all lanes
  // so the strobes alone select what memory keeps.
  function automatic logic [31:0] replicate(input logic [1:0] size, input logic [31:0] wdata);
    case (size)
      SZ_BYTE: replicate = {4{wdata[7:0]}};
      SZ_HALF: replicate = {2{wdata[15:0]}};
      default: replicate = wdata;
    endcase
  endfunction

  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] addr);
    case (size)
      SZ_HALF: misaligned = addr[0];
      SZ_WORD: misaligned = (addr != 2'b00);
      default: misaligned = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_data_bridge_load_aligner.sv
// load_aligner: combinational load-data extractor.
//   rdata     : raw 32-bit word from the data bus
//   addr      : byte offset of the access within the word
//   size      : SZ_BYTE / SZ_HALF / SZ_WORD
//   loadX     : 1 = sign-extend, 0 = zero-extend
//   ext_rdata : lane-selected, extended 32-bit result
module load_aligner
  import cpu_defs::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr,
  input  logic [1:0]  size,
  input  logic        loadX,
  output logic [31:0] ext_rdata
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;

  // Select the addressed lane and extend it to a full word.
  always_comb begin
    byte_s    = 8'h00;
    half_s    = 16'h0000;
    ext_rdata = 32'h0000_0000;
    case (addr)
      2'd0:    byte_s = rdata[7:0];
      2'd1:    byte_s = rdata[15:8];
      2'd2:    byte_s = rdata[23:16];
      default: byte_s = rdata[31:24];
    endcase
    if (addr[1]) begin
      half_s = rdata[31:16];
    end else begin
      half_s = rdata[15:0];
    end
    case (size)
      SZ_BYTE: ext_rdata = {{24{loadX & byte_s[7]}}, byte_s};
      SZ_HALF: ext_rdata = {{16{loadX & half_s[15]}}, half_s};
      default: ext_rdata = rdata;
    endcase
  end

endmodule

// File: rtl/mem_data_bridge.sv
// mem_data_bridge: MEM-stage responder that turns one pipeline data access
// into one SRAM-like bus transaction and stalls IF..MEM until it completes.
//   Pipeline side : mem_data_en/ren/wen/addr/wdata/loadX, flush in;
//                   stall (combinational), load_rdata/load_valid out.
//   Bus side      : data_req/wr/size/addr/wstrb/wdata out (registered);
//                   data_addr_ok/data_data_ok/data_rdata in.
//   adel/ades     : misaligned load/store pulse, active only when the macro
//                   DATA_BRIDGE_ALIGN_CHECK_EN is defined; otherwise 0.
// Reset: resetn, synchronous, active low.
module mem_data_bridge
  import cpu_defs::*;
(
  input  logic        clk,
  input  logic        resetn,
  input  logic        mem_data_en,
  input  logic [3:0]  mem_data_ren,
  input  logic [3:0]  mem_data_wen,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic        mem_loadX,
  input  logic        flush,
  output logic        stall,
  output logic [31:0] load_rdata,
  output logic        load_valid,
  output logic        data_req,
  output logic        data_wr,
  output logic [1:0]  data_size,
  output logic [31:0] data_addr,
  output logic [3:0]  data_wstrb,
  output logic [31:0] data_wdata,
  input  logic        data_addr_ok,
  input  logic        data_data_ok,
  input  logic [31:0] data_rdata,
  output logic        adel,
  output logic        ades
);

  br_state_e   state_q, state_d;
  logic        data_req_q;
  logic        data_wr_q;
  logic [1:0]  data_size_q;
  logic [31:0] data_addr_q;
  logic [3:0]  data_wstrb_q;
  logic [31:0] data_wdata_q;
  logic        loadx_q;
  logic [31:0] load_rdata_q;
  logic        load_valid_q;
  logic        adel_q;
  logic        ades_q;

  logic        access_s;
  logic        is_store_s;
  logic [1:0]  size_s;
  logic        misalign_s;
  logic        latch_s;
  logic        capture_s;
  logic        adel_s;
  logic        ades_s;
  logic [31:0] aligned_s;

  assign access_s   = mem_data_en && ((mem_data_ren | mem_data_wen) != 4'b0000);
  assign is_store_s = (mem_data_wen != 4'b0000);
  assign size_s     = mask_size(is_store_s ? mem_data_wen : mem_data_ren);

`ifdef DATA_BRIDGE_ALIGN_CHECK_EN
  assign misalign_s = misaligned(size_s, mem_addr[1:0]);
`else
  assign misalign_s = 1'b0;
`endif

  // Aligner works on the latched offset/size so the response can arrive
  // after the pipeline inputs have moved on.
  load_aligner u_load_aligner (
    .rdata     (data_rdata),
    .addr      (data_addr_q[1:0]),
    .size      (data_size_q),
    .loadX     (loadx_q),
    .ext_rdata (aligned_s)
  );

  // Next-state and control strobes for the single-outstanding bus FSM.
  always_comb begin
    state_d   = state_q;
    latch_s   = 1'b0;
    capture_s = 1'b0;
    adel_s    = 1'b0;
    ades_s    = 1'b0;
    case (state_q)
      BR_IDLE: begin
        if (access_s && !flush) begin
          if (misalign_s) begin
            adel_s = !is_store_s;
            ades_s = is_store_s;
          end else begin
            latch_s = 1'b1;
            state_d = BR_REQ;
          end
        end else begin
          state_d = BR_IDLE;
        end
      end
      BR_REQ: begin
        if (data_addr_ok) begin
          if (data_data_ok) begin
            // A response landing together with a flush is simply dropped.
            capture_s = !flush;
            state_d   = flush ? BR_IDLE : BR_DONE;
          end else begin
            state_d = flush ? BR_DRAIN : BR_WAIT;
          end
        end else if (flush) begin
          state_d = BR_IDLE;
        end else begin
          state_d = BR_REQ;
        end
      end
      BR_WAIT: begin
        if (data_data_ok) begin
          capture_s = !flush;
          state_d   = flush ? BR_IDLE : BR_DONE;
        end else if (flush) begin
          state_d = BR_DRAIN;
        end else begin
          state_d = BR_WAIT;
        end
      end
      BR_DRAIN: begin
        if (data_data_ok) begin
          state_d = BR_IDLE;
        end else begin
          state_d = BR_DRAIN;
        end
      end
      BR_DONE: state_d = BR_IDLE;
      default: state_d = BR_IDLE;
    endcase
  end

  // State, bus request fields and load result registers.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q      <= BR_IDLE;
      data_req_q   <= 1'b0;
      data_wr_q    <= 1'b0;
      data_size_q  <= 2'd0;
      data_addr_q  <= 32'h0000_0000;
      data_wstrb_q <= 4'b0000;
      data_wdata_q <= 32'h0000_0000;
      loadx_q      <= 1'b0;
      load_rdata_q <= 32'h0000_0000;
      load_valid_q <= 1'b0;
      adel_q       <= 1'b0;
      ades_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      data_req_q <= (state_d == BR_REQ);
      if (latch_s) begin
        data_wr_q    <= is_store_s;
        data_size_q  <= size_s;
        data_addr_q  <= mem_addr;
        data_wstrb_q <= mem_data_wen;
        data_wdata_q <= replicate(size_s, mem_wdata);
        loadx_q      <= mem_loadX;
      end
      load_valid_q <= capture_s && !data_wr_q;
      if (capture_s && !data_wr_q) begin
        load_rdata_q <= aligned_s;
      end
      adel_q <= adel_s;
      ades_q <= ades_s;
    end
  end

  // DONE is the cycle the access retires, so the pipeline is released there;
  // a rejected misaligned access also lets the pipeline advance.
  assign stall = resetn && access_s && (state_q != BR_DONE) && !flush &&
                 !((state_q == BR_IDLE) && misalign_s);

  assign data_req   = data_req_q;
  assign data_wr    = data_wr_q;
  assign data_size  = data_size_q;
  assign data_addr  = data_addr_q;
  assign data_wstrb = data_wstrb_q;
  assign data_wdata = data_wdata_q;
  assign load_rdata = load_rdata_q;
  assign load_valid = load_valid_q;
  assign adel       = adel_q;
  assign ades       = ades_q;

endmodule

// File: doc/mem_data_bridge.md
# mem_data_bridge

MEM-stage data-access responder. Consumes the data-request fields that the EX/MEM pipeline register presents to MEM (enable, byte read/write masks, address, raw store data, sign-extend flag). Converts each access into one transaction on the SRAM-like data bus (req/addr_ok/data_ok) and stalls the pipeline until it completes. Returns the lane-aligned, extended load result for writeback.

## Interface
Parameters:
- none. Bus width is fixed at 32 bits.

Ports:
- clk  in  1  pipeline clock; every register updates on the rising edge.
- resetn  in  1  synchronous, active-low reset.
- mem_data_en  in  1  MEM-stage instruction accesses memory.
- mem_data_ren  in  4  load byte mask, already lane-positioned.
- mem_data_wen  in  4  store byte mask, already lane-positioned.
- mem_addr  in  32  effective address (MEM-stage result).
- mem_wdata  in  32  raw rt value, not yet lane-shifted.
- mem_loadX  in  1  1 = sign-extend the load, 0 = zero-extend.
- flush  in  1  exception/eret flush of MEM.
- stall  out  1  hold IF..MEM; combinational.
- load_rdata  out  32  aligned, extended load result; registered.
- load_valid  out  1  1-cycle pulse with a completed load.
- data_req  out  1  SRAM-like request.
- data_wr  out  1  1 = write.
- data_size  out  2  0 = byte, 1 = half, 2 = word.
- data_addr  out  32  byte address.
- data_wstrb  out  4  write strobes.
- data_wdata  out  32  lane-replicated store data.
- data_addr_ok  in  1  request accepted.
- data_data_ok  in  1  response or write acknowledge.
- data_rdata  in  32  raw read word.
- adel  out  1  misaligned load, only when the macro is defined; otherwise 0.
- ades  out  1  misaligned store, only when the macro is defined; otherwise 0.

## Operation
- An access is present when mem_data_en=1 and (ren|wen)≠0.
- Size is the popcount of the active mask: 1→0, 2→1, 4→2.
- data_wstrb = wen.
- Store data is replicated into lanes: byte {4{wdata[7:0]}}, half {2{wdata[15:0]}}, word unchanged.
- FSM states: IDLE, REQ, WAIT, DRAIN, DONE.
  - IDLE: an access is present and flush=0 → latch all bus fields, loadX, addr[1:0] and size; go to REQ.
  - REQ: data_req=1. If addr_ok=1 and data_ok=1 → DONE. If addr_ok=1 only → WAIT. If flush=1 with addr_ok=0 → IDLE and the request is withdrawn. If flush=1 with addr_ok=1 → DRAIN.
  - WAIT: data_ok=1 → DONE and capture the load result. If flush=1 and data_ok=0 → DRAIN. If flush=1 and data_ok=1 → IDLE and the result is discarded.
  - DRAIN: wait for data_ok, discard it, go to IDLE. No new request is issued from DRAIN.
  - DONE: load_valid=1 for a load; go to IDLE.
- stall = access present AND state≠DONE AND flush=0. stall is forced to 0 while resetn=0.
- Load extraction from the latched addr[1:0]:
  - byte: data_rdata lane addr[1:0].
  - half: lane addr[1].
  - word: whole word.
  - Extension to 32 bits follows loadX.
- Stores never pulse load_valid.

## Timing
- Reset values: state IDLE, data_req 0, data_wr 0, data_size 0, data_addr 0, data_wstrb 0, data_wdata 0, load_rdata 0, load_valid 0, adel 0, ades 0.
- data_req rises one cycle after the access first appears.
- Minimum latency is 3 cycles from the access appearing to stall=0: IDLE→REQ→DONE, with addr_ok and data_ok both high in the REQ cycle.
- Bus fields stay stable while data_req=1 and addr_ok=0.
- Exactly one outstanding transaction at any time.
- load_rdata is valid in the DONE cycle and holds until the next load completes.

## Configuration
- DATA_BRIDGE_ALIGN_CHECK_EN defined: in IDLE, a half access with addr[0]=1 or a word access with addr[1:0]≠0 issues no request.
  - adel (load) or ades (store) pulses for 1 cycle.
  - stall is 0 in that cycle and the state stays IDLE.
- Not defined: adel and ades are tied to 0; every address is issued unchanged.

## Structure
- Shared package cpu_defs holds:
  - the FSM state encoding (BR_IDLE, BR_REQ, BR_WAIT, BR_DRAIN, BR_DONE);
  - the size codes SZ_BYTE, SZ_HALF, SZ_WORD.
- One sub-module, load_aligner: combinational extractor with inputs (rdata, addr[1:0], size, loadX) and a 32-bit extended output.

## Test plan
- Byte load lb, addr 0x1003, rdata 0x80xxxxxx, addr_ok and data_ok in the same cycle → load_rdata 0xFFFFFF80, load_valid 1 cycle, stall high 2 cycles.
- sh, addr 0x2002, wdata 0x0000BEEF → data_wr 1, size 1, wstrb 0b1100, data_wdata 0xBEEFBEEF, no load_valid.
- lw with addr_ok held 0 for 4 cycles, then data_ok 3 cycles later → req and addr stable throughout; load_rdata equals rdata; stall released in DONE.
- flush in WAIT → DRAIN. A new lw arriving before data_ok gets no request until one cycle after data_ok; the first response raises no load_valid.
- flush in REQ with addr_ok=0 → data_req drops next cycle, state IDLE, no DRAIN.
- With DATA_BRIDGE_ALIGN_CHECK_EN, lw at 0x3001 → adel pulse, data_req stays 0, stall 0.
